// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line in, the received byte and status strobes out.
// The master side drives rx. The slave side is the receiver.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data_out, data_valid, frame_err, busy
  );

  modport slave (
    input  rx,
    output data_out, data_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling.
// The incoming line is synchronised first. A free-running counter produces one
// tick per oversample period. A single registered FSM finds the start bit,
// samples each bit at its centre and checks the stop bit.
// A low stop bit is reported as a framing error. The receiver then parks in
// BRK until the line returns high, so a held-low line cannot re-trigger it.
module uart_rx #(
  parameter int OS_CNT = 651, // clk cycles per oversample tick
  parameter int OS_BIT = 10   // tick counter width, 2**OS_BIT > OS_CNT-1
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam logic [OS_BIT-1:0] OS_MAX = OS_BIT'(OS_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  logic              rx_meta;
  logic              rxs;
  logic [OS_BIT-1:0] os_cnt;
  logic              tick;

  state_t            state;
  logic [3:0]        s;
  logic [2:0]        n;
  logic [7:0]        shift;
  logic [7:0]        data_out_r;
  logic              data_valid_r;
  logic              frame_err_r;
  logic              busy_r;

  // Two-flop synchroniser. Both flops reset to the idle-high line level, so
  // releasing reset does not look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make rxs take the previous rx_meta.
      // With blocking assignments the two flops would collapse into one.
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  // Free-running oversample counter. It wraps at OS_CNT-1 and never restarts
  // on a start edge, so start detection jitters by up to one tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt <= '0;
    end else if (os_cnt == OS_MAX) begin
      os_cnt <= '0;
    end else begin
      os_cnt <= os_cnt + 1'b1;
    end
  end

  assign tick = (os_cnt == OS_MAX);

  // Receive FSM. Every output is registered, and the pulses last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shift        <= '0;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      // NOTE: the strobes default low on every cycle. Only the branch that
      // finishes a frame raises them, which gives exactly one-cycle pulses.
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;

      case (state)
        IDLE: begin
          // Leave IDLE on any cycle, so a start edge is seen without waiting for a tick.
          if (!rxs) begin
            state  <= START;
            s      <= '0;
            n      <= '0;
            busy_r <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (s == 4'd7) begin
              // Mid start bit: the line must still be low, otherwise it was a glitch.
              if (!rxs) begin
                state <= DATA;
                s     <= '0;
              end else begin
                state  <= IDLE;
                busy_r <= 1'b0;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (s == 4'd15) begin
              // Bit centre. The line is LSB first, so each bit shifts in from the top.
              shift <= {rxs, shift[7:1]};
              s     <= '0;
              n     <= n + 3'd1;
              if (n == 3'd7) begin
                state <= STOP;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (s == 4'd15) begin
              s <= '0;
              if (rxs) begin
                data_out_r   <= shift;
                data_valid_r <= 1'b1;
                state        <= IDLE;
                busy_r       <= 1'b0;
              end else begin
                frame_err_r <= 1'b1;
                state       <= BRK;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end

        BRK: begin
          // Wait here until the line is released. A held-low line must not start a new frame.
          if (tick && rxs) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx with OS_CNT=4, so one bit lasts 64 clk.
// The stimulus pushes each expected event into a scoreboard queue when it
// sends a frame. A monitor pops an entry on every data_valid or frame_err
// pulse and compares it with the outputs.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.OS_CNT(4), .OS_BIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  logic [7:0] model_last = 8'h00;
  int   n_dv_exp = 0;
  int   n_fe_exp = 0;
  int   n_dv = 0;
  int   n_fe = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  bit   check_lat = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every output pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_valid || bus.frame_err) begin
        check("dv_fe_exclusive", {31'd0, bus.data_valid & bus.frame_err}, 32'd0);
      end
      if (bus.data_valid) begin
        n_dv++;
        check("busy_low_at_dv", {31'd0, bus.busy}, 32'd0);
        if (check_lat) begin
          check("latency_in_range",
                {31'd0, ((cyc - start_cyc) >= 604) && ((cyc - start_cyc) <= 616)}, 32'd1);
          check_lat = 1'b0;
        end
        if (sb_q.size() == 0) begin
          check("dv_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("dv_kind", {31'd0, e.is_err}, 32'd0);
          check("dv_data", {24'd0, bus.data_out}, {24'd0, e.data});
        end
      end
      if (bus.frame_err) begin
        n_fe++;
        if (sb_q.size() == 0) begin
          check("fe_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("fe_kind", {31'd0, e.is_err}, 32'd1);
          check("fe_data_held", {24'd0, bus.data_out}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic push_data(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    sb_q.push_back(e);
    model_last = d;
    n_dv_exp++;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = model_last;
    sb_q.push_back(e);
    n_fe_exp++;
  endtask

  task automatic drive_bit(input logic v, input int clks);
    bus.rx = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int clks);
    start_cyc = cyc;
    drive_bit(1'b0, clks);
    for (int i = 0; i < 8; i++) drive_bit(d[i], clks);
    drive_bit(stop, clks);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    check("rst_dv", {31'd0, bus.data_valid}, 32'd0);
    check("rst_fe", {31'd0, bus.frame_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    drive_bit(1'b1, 20);

    // Single 0x55 frame, with a latency check
    check_lat = 1'b1;
    push_data(8'h55);
    send_frame(8'h55, 1'b1, BIT_CLKS);
    wait_idle("idle_after_55", 200);
    drive_bit(1'b1, BIT_CLKS);
    check("lat_checked", {31'd0, check_lat}, 32'd0);

    // Back-to-back frames with no idle gap
    begin
      logic [7:0] bb [4];
      bb[0] = 8'hA5; bb[1] = 8'h3C; bb[2] = 8'hFF; bb[3] = 8'h00;
      for (int i = 0; i < 4; i++) begin
        push_data(bb[i]);
        send_frame(bb[i], 1'b1, BIT_CLKS);
      end
    end
    wait_idle("idle_after_bb", 200);
    drive_bit(1'b1, BIT_CLKS);

    // Start glitch: 16 clk low, then high
    drive_bit(1'b0, 16);
    drive_bit(1'b1, BIT_CLKS);
    check("glitch_busy", {31'd0, bus.busy}, 32'd0);
    check("glitch_data_held", {24'd0, bus.data_out}, {24'd0, model_last});

    // Framing error, held break, then recovery
    push_err();
    send_frame(8'h81, 1'b0, BIT_CLKS);
    drive_bit(1'b0, 3 * BIT_CLKS);
    check("brk_busy", {31'd0, bus.busy}, 32'd1);
    check("brk_data_held", {24'd0, bus.data_out}, {24'd0, model_last});
    bus.rx = 1'b1;
    wait_idle("brk_release", 20);
    drive_bit(1'b1, BIT_CLKS);
    push_data(8'h42);
    send_frame(8'h42, 1'b1, BIT_CLKS);
    wait_idle("idle_after_42", 200);
    drive_bit(1'b1, BIT_CLKS);

    // Reset in the middle of bit 4 of 0x96
    begin
      logic [7:0] d;
      d = 8'h96;
      drive_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLKS);
      drive_bit(d[4], BIT_CLKS / 2);
    end
    rst = 1'b1;
    model_last = 8'h00;
    #2;
    check("midrst_data_out", {24'd0, bus.data_out}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_dv", {31'd0, bus.data_valid}, 32'd0);
    drive_bit(1'b1, 10);
    rst = 1'b0;
    drive_bit(1'b1, BIT_CLKS);
    push_data(8'h69);
    send_frame(8'h69, 1'b1, BIT_CLKS);
    wait_idle("idle_after_69", 200);
    drive_bit(1'b1, BIT_CLKS);

    // 0x5A at +3% and -3% baud error
    push_data(8'h5A);
    send_frame(8'h5A, 1'b1, 66);
    wait_idle("idle_after_slow", 200);
    drive_bit(1'b1, BIT_CLKS);
    push_data(8'h5A);
    send_frame(8'h5A, 1'b1, 62);
    wait_idle("idle_after_fast", 200);
    drive_bit(1'b1, 2 * BIT_CLKS);

    check("sb_empty", sb_q.size(), 32'd0);
    check("dv_count", n_dv, n_dv_exp);
    check("fe_count", n_fe, n_fe_exp);
    check("final_data", {24'd0, bus.data_out}, 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net in case a wait never ends
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001: Parameter OS_CNT, default 651, clk cycles per oversample tick (16 ticks per bit; 100 MHz / 9600 baud).
REQ-002: Parameter OS_BIT, default 10, width of the oversample tick counter; 2^OS_BIT SHALL be > OS_CNT-1.
REQ-003: clk  input  1  system clock; all state updates on posedge clk.
REQ-004: rst  input  1  reset, asynchronous, active-high.
REQ-005: rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-006: data_out  output  8  last correctly framed byte; held until the next valid byte.
REQ-007: data_valid  output  1  one-cycle pulse; data_out is new in the same cycle.
REQ-008: frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009: busy  output  1  high in every state except IDLE.

Function
REQ-010: rx SHALL pass through a 2-flop synchronizer; both flops reset to 1; all logic uses the synchronized value rxs only.
REQ-011: Tick counter SHALL be free-running 0..OS_CNT-1 and wrap to 0; tick is high for one cycle when count == OS_CNT-1.
REQ-012: States SHALL be IDLE, START, DATA, STOP and BRK; all except the IDLE-to-START transition advance only on cycles where tick is high.
REQ-013: IDLE: rxs == 0 on any cycle -> START; sample counter s := 0; bit counter n := 0.
REQ-014: START: on each tick, s increments by 1; when s == 7 (mid start bit):
  - rxs == 0 -> DATA, s := 0;
  - rxs == 1 -> IDLE as a glitch, with no output pulse.
REQ-015: DATA: on each tick, s increments by 1; when s == 15:
  - shift register := {rxs, shift[7:1]};
  - s := 0 and n increments by 1;
  - the tick that samples n == 7 SHALL move to STOP.
REQ-016: STOP: on the tick with s == 15:
  - rxs == 1 -> data_out := shift register, data_valid = 1 in the next cycle, -> IDLE;
  - rxs == 0 -> frame_err = 1 in the next cycle, data_out unchanged, -> BRK.
REQ-017: BRK: remain in BRK while rxs == 0; go to IDLE on the first cycle with rxs == 1; no re-arm on a held-low line.
REQ-018: data_valid and frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one clk cycle per frame.
REQ-019: s SHALL be 4 bits and n SHALL be 3 bits; wrap SHALL never be relied on, because transitions occur at the stated values.
REQ-020: Start-edge detection jitter SHALL be at most OS_CNT cycles; the nominal sample point is the bit centre ±1/16 bit.
REQ-021: data_valid SHALL assert 9.5 bit times (152 ticks) after the start edge, ±1 tick plus 2 sync cycles.
REQ-022: IDLE accepts a new start bit immediately after the data_valid cycle; back-to-back frames with a 1-bit stop SHALL be received without loss.

Reset
REQ-023: On rst, these SHALL clear asynchronously to 0: data_out, data_valid, frame_err, busy, the tick counter, s, n and the shift register.
REQ-024: On rst, the state SHALL be IDLE and the synchronizer flops SHALL be set to 1.
REQ-025: Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception resumes on the next falling edge of rxs.

Verification (OS_CNT=4, bit = 64 clk)
REQ-026: Send 0x55 with stop = 1 -> exactly one data_valid pulse, data_out = 0x55, frame_err stays 0, busy falls in the same cycle.
REQ-027: Send back-to-back 0xA5, 0x3C, 0xFF, 0x00 with no idle gap -> four data_valid pulses carrying those values in order.
REQ-028: Drive rx low for 16 clk (4 ticks, less than half a bit), then high -> return to IDLE, no pulse, data_out unchanged.
REQ-029: Send 0x81 with stop = 0, hold rx low for 3 bit times, then send 0x42 -> frame_err pulse once, data_out unchanged, state BRK until rx high, then data_out = 0x42 with data_valid.
REQ-030: Assert rst during bit 4 of 0x96, then release and send 0x69 -> outputs 0 during reset, no pulse for 0x96, data_out = 0x69.
REQ-031: Send 0x5A at ±3% baud error -> data_out = 0x5A, frame_err = 0.
